// File: rtl/aqed_pair_monitor.sv
// aqed_pair_monitor
//   A-QED functional-consistency monitor for a single in-order stream unit.
//   One accepted write, chosen through exec_dup, becomes the "original". Its
//   data is replayed on a later exec_dup write as the "duplicate". Both are
//   tracked by input sequence index, and their outputs are captured by output
//   sequence index. A mismatch between the two captured outputs raises a
//   sticky qed_fail.
//
// Parameters
//   DATA_WIDTH  data path width
//   CNT_WIDTH   width of the in/out sequence counters, which saturate at all-ones
//   RB_BOUND    response bound in enabled cycles (only used with AQED_RB_EN)
//
// Build option
//   AQED_RB_EN  enables the response-bound watchdog (wait_cnt / rb_fail).
//               When it is undefined, rb_fail is tied to 0.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   clk_en                 gates every state update
//   flush, full            block input acceptance
//   exec_dup               permits an orig/dup issue this cycle
//   wen_in, data_in        write request and data from the environment
//   data_out               data toward the DUT (orig_in while issuing dup)
//   empty, valid_out       DUT output handshake
//   data_out_in            DUT output data
//   qed_done               both outputs captured
//   qed_check              0 only when done and the captured outputs differ
//   qed_fail               sticky mismatch flag
//   rb_fail                sticky response-bound violation flag
module aqed_pair_monitor #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned RB_BOUND   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  exec_dup,
  input  logic                  wen_in,
  input  logic                  full,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  valid_out,
  input  logic [DATA_WIDTH-1:0] data_out_in,
  output logic                  qed_done,
  output logic                  qed_check,
  output logic                  qed_fail,
  output logic                  rb_fail
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DUP  = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                  state, state_next;
  logic [CNT_WIDTH-1:0]    in_count, out_count;
  logic [CNT_WIDTH-1:0]    orig_idx, dup_idx;
  logic [DATA_WIDTH-1:0]   orig_in, orig_out, dup_out;
  logic                    orig_cap, dup_cap;
  logic                    qed_fail_q;

  logic                    acc_in, acc_out;
  logic                    issue_orig, issue_dup;
  logic                    cap_orig, cap_dup;
  logic                    enter_done;

  // A saturated input counter blocks acceptance, so indices never wrap.
  assign acc_in  = clk_en & ~reset & wen_in & ~full & ~flush & (in_count != CNT_MAX);
  assign acc_out = clk_en & ~reset & ~empty & valid_out & (out_count < in_count);

  // The captures are write-once. Because the counters are monotonic, only one
  // output can ever match each index.
  assign cap_orig = acc_out & (out_count == orig_idx) & (state != IDLE) & ~orig_cap;
  assign cap_dup  = acc_out & (out_count == dup_idx) &
                    ((state == WAIT_RESP) | (state == DONE)) & ~dup_cap;

  always_comb begin
    state_next = state;
    issue_orig = 1'b0;
    issue_dup  = 1'b0;
    case (state)
      IDLE: begin
        if (acc_in && exec_dup) begin
          issue_orig = 1'b1;
          state_next = WAIT_DUP;
        end
      end
      WAIT_DUP: begin
        if (acc_in && exec_dup) begin
          issue_dup  = 1'b1;
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (orig_cap && dup_cap) state_next = DONE;
      end
      default: state_next = state;
    endcase
  end

  assign enter_done = (state == WAIT_RESP) && (state_next == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_count   <= '0;
      out_count  <= '0;
      orig_idx   <= '0;
      dup_idx    <= '0;
      orig_in    <= '0;
      orig_out   <= '0;
      dup_out    <= '0;
      orig_cap   <= 1'b0;
      dup_cap    <= 1'b0;
      qed_fail_q <= 1'b0;
    end else if (clk_en) begin
      state <= state_next;
      if (acc_in)  in_count  <= in_count + 1'b1;
      if (acc_out) out_count <= out_count + 1'b1;
      if (issue_orig) begin
        orig_in  <= data_in;
        orig_idx <= in_count;
      end
      if (issue_dup) dup_idx <= in_count;
      if (cap_orig) begin
        orig_out <= data_out_in;
        orig_cap <= 1'b1;
      end
      if (cap_dup) begin
        dup_out <= data_out_in;
        dup_cap <= 1'b1;
      end
      if (enter_done && (orig_out != dup_out)) qed_fail_q <= 1'b1;
    end
  end

  assign data_out  = issue_dup ? orig_in : data_in;
  assign qed_done  = (state == DONE);
  assign qed_check = ~((state == DONE) && (orig_out != dup_out));
  assign qed_fail  = qed_fail_q;

`ifdef AQED_RB_EN
  localparam int unsigned WAIT_W = $clog2(RB_BOUND + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              rb_fail_q;

  // rb_fail is raised on the same edge at which wait_cnt reaches RB_BOUND.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      rb_fail_q <= 1'b0;
    end else if (clk_en) begin
      if (acc_out) begin
        wait_cnt <= '0;
      end else if (((state == WAIT_DUP) || (state == WAIT_RESP)) &&
                   (in_count > out_count) &&
                   (wait_cnt != WAIT_W'(RB_BOUND))) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_W'(RB_BOUND - 1)) rb_fail_q <= 1'b1;
      end
    end
  end

  assign rb_fail = rb_fail_q;
`else
  assign rb_fail = 1'b0;
`endif

endmodule

// File: tb/tb_aqed_pair_monitor.sv
module tb_aqed_pair_monitor;

`ifdef AQED_RB_EN
  localparam int unsigned RB = 4;
`else
  localparam int unsigned RB = 64;
`endif

  logic        clk = 1'b0;
  logic        reset, clk_en, flush, exec_dup, wen_in, full, empty, valid_out;
  logic [15:0] data_in, data_out, data_out_in;
  logic        qed_done, qed_check, qed_fail, rb_fail;

  logic        s_reset, s_wen_in, s_exec_dup, s_valid_out;
  logic [15:0] s_data_in, s_data_out, s_data_out_in;
  logic        s_qed_done, s_qed_check, s_qed_fail, s_rb_fail;

  int unsigned pass_cnt = 0;
  int unsigned check_cnt = 0;

  always #5 clk = ~clk;

  aqed_pair_monitor #(.DATA_WIDTH(16), .CNT_WIDTH(32), .RB_BOUND(RB)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .exec_dup(exec_dup),
    .wen_in(wen_in), .full(full), .data_in(data_in), .data_out(data_out),
    .empty(empty), .valid_out(valid_out), .data_out_in(data_out_in),
    .qed_done(qed_done), .qed_check(qed_check), .qed_fail(qed_fail), .rb_fail(rb_fail)
  );

  aqed_pair_monitor #(.DATA_WIDTH(16), .CNT_WIDTH(2), .RB_BOUND(RB)) dut_sat (
    .clk(clk), .reset(s_reset), .clk_en(1'b1), .flush(1'b0), .exec_dup(s_exec_dup),
    .wen_in(s_wen_in), .full(1'b0), .data_in(s_data_in), .data_out(s_data_out),
    .empty(1'b0), .valid_out(s_valid_out), .data_out_in(s_data_out_in),
    .qed_done(s_qed_done), .qed_check(s_qed_check), .qed_fail(s_qed_fail), .rb_fail(s_rb_fail)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    clk_en = 1'b1; flush = 1'b0; exec_dup = 1'b0; wen_in = 1'b0; full = 1'b0;
    empty = 1'b0; valid_out = 1'b0; data_in = 16'h0000; data_out_in = 16'h0000;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic write(input logic [15:0] d, input logic dup);
    wen_in = 1'b1; exec_dup = dup; data_in = d;
    step();
    wen_in = 1'b0; exec_dup = 1'b0;
  endtask

  task automatic emit(input logic [15:0] d);
    valid_out = 1'b1; data_out_in = d;
    step();
    valid_out = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    data_in = 16'hBEEF;
    #1;
    check_cnt++; if (data_out !== 16'hBEEF) $display("FAIL reset_data_out got %h want beef", data_out); else pass_cnt++;
    check_cnt++; if (qed_done !== 1'b0) $display("FAIL reset_done got %b want 0", qed_done); else pass_cnt++;
    check_cnt++; if (qed_check !== 1'b1) $display("FAIL reset_check got %b want 1", qed_check); else pass_cnt++;
    check_cnt++; if (qed_fail !== 1'b0) $display("FAIL reset_fail got %b want 0", qed_fail); else pass_cnt++;
    check_cnt++; if (rb_fail !== 1'b0) $display("FAIL reset_rb got %b want 0", rb_fail); else pass_cnt++;
  endtask

  task automatic test_pair(input logic [15:0] dup_val, input logic match);
    do_reset();
    write(16'h1234, 1'b1);
    write(16'h5678, 1'b0);
    wen_in = 1'b1; exec_dup = 1'b1; data_in = 16'hAAAA;
    #1;
    check_cnt++; if (data_out !== 16'h1234) $display("FAIL pair_issue_dup got %h want 1234", data_out); else pass_cnt++;
    step();
    wen_in = 1'b0; exec_dup = 1'b0;
    check_cnt++; if (dut.in_count !== 32'd3) $display("FAIL pair_in_count got %0d want 3", dut.in_count); else pass_cnt++;
    emit(16'h1234);
    emit(16'h5678);
    emit(dup_val);
    check_cnt++; if (qed_done !== 1'b0) $display("FAIL pair_done_early got %b want 0", qed_done); else pass_cnt++;
    step();
    check_cnt++; if (qed_done !== 1'b1) $display("FAIL pair_done got %b want 1", qed_done); else pass_cnt++;
    check_cnt++; if (qed_check !== match) $display("FAIL pair_check got %b want %b", qed_check, match); else pass_cnt++;
    check_cnt++; if (qed_fail !== !match) $display("FAIL pair_fail got %b want %b", qed_fail, !match); else pass_cnt++;
    write(16'h0001, 1'b1);
    emit(16'h0001);
    write(16'h0002, 1'b1);
    step();
    check_cnt++; if (qed_fail !== !match) $display("FAIL pair_fail_sticky got %b want %b", qed_fail, !match); else pass_cnt++;
    check_cnt++; if (qed_done !== 1'b1) $display("FAIL pair_done_hold got %b want 1", qed_done); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    write(16'hC0DE, 1'b1);
    wen_in = 1'b1; exec_dup = 1'b1; data_in = 16'h9999;
    valid_out = 1'b1; data_out_in = 16'hC0DE;
    #1;
    check_cnt++; if (data_out !== 16'hC0DE) $display("FAIL b2b_issue got %h want c0de", data_out); else pass_cnt++;
    step();
    wen_in = 1'b0; exec_dup = 1'b0; valid_out = 1'b0;
    check_cnt++; if (dut.out_count !== 32'd1) $display("FAIL b2b_out_count got %0d want 1", dut.out_count); else pass_cnt++;
    emit(16'hC0DE);
    step();
    check_cnt++; if (qed_done !== 1'b1) $display("FAIL b2b_done got %b want 1", qed_done); else pass_cnt++;
    check_cnt++; if (qed_check !== 1'b1) $display("FAIL b2b_check got %b want 1", qed_check); else pass_cnt++;
  endtask

  task automatic test_blocked;
    do_reset();
    full = 1'b1;
    write(16'hDEAD, 1'b1);
    full = 1'b0; flush = 1'b1;
    write(16'hDEAD, 1'b1);
    flush = 1'b0; clk_en = 1'b0;
    write(16'hDEAD, 1'b1);
    clk_en = 1'b1;
    check_cnt++; if (dut.in_count !== 32'd0) $display("FAIL blocked_in_count got %0d want 0", dut.in_count); else pass_cnt++;
    check_cnt++; if (2'(dut.state) !== 2'd0) $display("FAIL blocked_state got %0d want 0", 2'(dut.state)); else pass_cnt++;
    write(16'h1111, 1'b1);
    wen_in = 1'b1; exec_dup = 1'b1; data_in = 16'h2222; clk_en = 1'b0;
    #1;
    check_cnt++; if (data_out !== 16'h2222) $display("FAIL gated_no_issue got %h want 2222", data_out); else pass_cnt++;
    clk_en = 1'b1;
    #1;
    check_cnt++; if (data_out !== 16'h1111) $display("FAIL blocked_then_dup got %h want 1111", data_out); else pass_cnt++;
    step();
    wen_in = 1'b0; exec_dup = 1'b0;
  endtask

  task automatic test_mid_reset;
    do_reset();
    write(16'h7777, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_cnt++; if (dut.in_count !== 32'd0) $display("FAIL midrst_in_count got %0d want 0", dut.in_count); else pass_cnt++;
    wen_in = 1'b1; exec_dup = 1'b1; data_in = 16'h3333;
    #1;
    check_cnt++; if (data_out !== 16'h3333) $display("FAIL midrst_no_dup got %h want 3333", data_out); else pass_cnt++;
    step();
    wen_in = 1'b0; exec_dup = 1'b0;
  endtask

  task automatic test_saturation;
    s_wen_in = 1'b0; s_exec_dup = 1'b0; s_valid_out = 1'b0; s_data_in = '0; s_data_out_in = '0;
    s_reset = 1'b1;
    step(); step();
    s_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_wen_in = 1'b1; s_data_in = 16'(i);
      step();
    end
    s_exec_dup = 1'b1; s_data_in = 16'h4444;
    #1;
    check_cnt++; if (s_data_out !== 16'h4444) $display("FAIL sat_data_out got %h want 4444", s_data_out); else pass_cnt++;
    step();
    s_data_in = 16'h5555;
    step();
    s_wen_in = 1'b0; s_exec_dup = 1'b0;
    check_cnt++; if (dut_sat.in_count !== 2'd3) $display("FAIL sat_in_count got %0d want 3", dut_sat.in_count); else pass_cnt++;
    check_cnt++; if (2'(dut_sat.state) !== 2'd0) $display("FAIL sat_state got %0d want 0", 2'(dut_sat.state)); else pass_cnt++;
    s_valid_out = 1'b1;
    for (int i = 0; i < 4; i++) step();
    s_valid_out = 1'b0;
    step();
    check_cnt++; if (dut_sat.out_count !== 2'd3) $display("FAIL sat_out_count got %0d want 3", dut_sat.out_count); else pass_cnt++;
    check_cnt++; if (s_qed_done !== 1'b0) $display("FAIL sat_done got %b want 0", s_qed_done); else pass_cnt++;
  endtask

  task automatic test_rb;
    do_reset();
    write(16'h0ABC, 1'b1);
`ifdef AQED_RB_EN
    step(); step(); step();
    check_cnt++; if (rb_fail !== 1'b0) $display("FAIL rb_early got %b want 0", rb_fail); else pass_cnt++;
    step();
    check_cnt++; if (rb_fail !== 1'b1) $display("FAIL rb_set got %b want 1", rb_fail); else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_cnt++; if (rb_fail !== 1'b0) $display("FAIL rb_reset got %b want 0", rb_fail); else pass_cnt++;
    check_cnt++; if (2'(dut.state) !== 2'd0) $display("FAIL rb_state got %0d want 0", 2'(dut.state)); else pass_cnt++;
`else
    for (int i = 0; i < 80; i++) step();
    check_cnt++; if (rb_fail !== 1'b0) $display("FAIL rb_disabled got %b want 0", rb_fail); else pass_cnt++;
`endif
  endtask

  initial begin
    s_reset = 1'b1; s_wen_in = 1'b0; s_exec_dup = 1'b0; s_valid_out = 1'b0;
    s_data_in = '0; s_data_out_in = '0;
    test_reset();
    test_pair(16'h1234, 1'b1);
    test_pair(16'h1235, 1'b0);
    test_back_to_back();
    test_blocked();
    test_mid_reset();
    test_saturation();
    test_rb();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
